// File: rtl/seq_det_pkg.sv
// Shared types, helpers and reset configuration for the parametrised sequence detector.
package seq_det_pkg;

    localparam int MASK_W  = 64;
    localparam int RST_LEN = 1;
    localparam bit RST_OVL = 1'b1;

    function automatic int len_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction

    // Low-aligned mask with the lowest len bits set; callers zero-extend their operands to MASK_W.
    function automatic logic [MASK_W-1:0] len_mask(input int len);
        logic [MASK_W-1:0] m;
        m = '0;
        for (int i = 0; i < MASK_W; i++) begin
            if (i < len) begin
                m[i] = 1'b1;
            end
        end
        return m;
    endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all ones instead of wrapping.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    always_ff @(posedge clock) begin
        if (reset || clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detector_param.sv
// Runtime-programmable serial pattern detector with overlap control and saturating match count.
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               en,
    input  logic               din,
    input  logic               load,
    input  logic [MAX_LEN-1:0] pat,
    input  logic [LEN_W-1:0]   pat_len,
    input  logic               overlap,
    output logic               match,
    output logic [CNT_W-1:0]   match_count,
    output logic [LEN_W-1:0]   fill,
    output logic               cfg_err
);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pat_r;
    logic [LEN_W-1:0]   len_r;
    logic               ovl_r;

    logic               cfg_ok;
    logic [MAX_LEN-1:0] hist_n;
    logic [LEN_W-1:0]   fill_n;
    logic [MASK_W-1:0]  diff;
    logic               hit;
    logic               sample;

    assign cfg_ok = (pat_len != '0) && (pat_len <= LEN_W'(MAX_LEN));
    assign sample = en && !load;

    always_comb begin
        hist_n = {hist[MAX_LEN-2:0], din};
        fill_n = (fill == LEN_W'(MAX_LEN)) ? fill : fill + 1'b1;
        diff   = MASK_W'(hist_n ^ pat_r) & len_mask(int'(len_r));
        hit    = (fill_n >= len_r) && (diff == '0);
    end

    // Load always wins over en, whether the new configuration is accepted or not.
    always_ff @(posedge clock) begin
        if (reset) begin
            hist    <= '0;
            fill    <= '0;
            match   <= 1'b0;
            cfg_err <= 1'b0;
            pat_r   <= '0;
            len_r   <= LEN_W'(RST_LEN);
            ovl_r   <= RST_OVL;
        end else if (load) begin
            match   <= 1'b0;
            cfg_err <= !cfg_ok;
            if (cfg_ok) begin
                pat_r <= pat;
                len_r <= pat_len;
                ovl_r <= overlap;
                hist  <= '0;
                fill  <= '0;
            end
        end else if (en) begin
            hist    <= hist_n;
            fill    <= (hit && !ovl_r) ? '0 : fill_n;
            match   <= hit;
            cfg_err <= 1'b0;
        end else begin
            match   <= 1'b0;
            cfg_err <= 1'b0;
        end
    end

    sat_counter #(.W(CNT_W)) u_match_count (
        .clock (clock),
        .reset (reset),
        .clr   (load && cfg_ok),
        .inc   (sample && hit),
        .q     (match_count)
    );

endmodule

// File: tb/tb_seq_detector_param.sv
// Directed self-checking bench for seq_detector_param; a second copy with a 2-bit counter shows saturation.
module tb_seq_detector_param;

    localparam int MAX_LEN = 8;
    localparam int LEN_W   = 4;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               en = 1'b0;
    logic               din = 1'b0;
    logic               load = 1'b0;
    logic [MAX_LEN-1:0] pat = '0;
    logic [LEN_W-1:0]   pat_len = '0;
    logic               overlap = 1'b0;

    logic               match, cfg_err, match_s, cfg_err_s;
    logic [7:0]         match_count;
    logic [1:0]         count_s;
    logic [LEN_W-1:0]   fill, fill_s;

    int pass_count = 0;
    int total_count = 0;

    always #5 clock = ~clock;

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(8)) dut (
        .clock(clock), .reset(reset), .en(en), .din(din), .load(load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap),
        .match(match), .match_count(match_count), .fill(fill), .cfg_err(cfg_err)
    );

    seq_detector_param #(.MAX_LEN(MAX_LEN), .CNT_W(2)) dut_small (
        .clock(clock), .reset(reset), .en(en), .din(din), .load(load),
        .pat(pat), .pat_len(pat_len), .overlap(overlap),
        .match(match_s), .match_count(count_s), .fill(fill_s), .cfg_err(cfg_err_s)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_count++;
        assert (observed === expected) pass_count++;
        else $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    endtask

    task automatic apply_stimulus(input logic r, input logic e, input logic d, input logic l,
                                  input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] n,
                                  input logic o);
        @(negedge clock);
        reset = r; en = e; din = d; load = l; pat = p; pat_len = n; overlap = o;
        @(posedge clock);
        #1;
    endtask

    task automatic do_load(input logic [MAX_LEN-1:0] p, input logic [LEN_W-1:0] n, input logic o);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1, p, n, o);
    endtask

    task automatic do_bit(input logic d);
        apply_stimulus(1'b0, 1'b1, d, 1'b0, '0, '0, 1'b0);
    endtask

    task automatic do_idle();
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
    endtask

    logic s1_bits [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic s1_ovl  [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic s1_novl [7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        $display("[TB] start");
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'hFF, 4'd4, 1'b0);
        check_output("rst_match", 32'(match), 0);
        check_output("rst_count", 32'(match_count), 0);
        check_output("rst_fill", 32'(fill), 0);
        check_output("rst_cfg_err", 32'(cfg_err), 0);

        // Reset configuration is len 1, pattern 0: a sampled 0 matches, a 1 does not.
        do_bit(1'b0);
        check_output("rstcfg_zero_match", 32'(match), 1);
        do_bit(1'b1);
        check_output("rstcfg_one_nomatch", 32'(match), 0);
        check_output("rstcfg_fill", 32'(fill), 2);

        // Scenario 1: overlapping 1101.
        do_load(8'b0000_1101, 4'd4, 1'b1);
        check_output("s1_load_count", 32'(match_count), 0);
        check_output("s1_load_fill", 32'(fill), 0);
        for (int i = 0; i < 7; i++) begin
            do_bit(s1_bits[i]);
            check_output($sformatf("s1_match_b%0d", i + 1), 32'(match), 32'(s1_ovl[i]));
        end
        check_output("s1_count", 32'(match_count), 2);
        check_output("s1_fill", 32'(fill), 7);

        // Scenario 2: same stream, non-overlapping.
        do_load(8'b0000_1101, 4'd4, 1'b0);
        for (int i = 0; i < 7; i++) begin
            do_bit(s1_bits[i]);
            check_output($sformatf("s2_match_b%0d", i + 1), 32'(match), 32'(s1_novl[i]));
        end
        check_output("s2_count", 32'(match_count), 1);
        check_output("s2_fill", 32'(fill), 3);

        // Scenario 3: 1111 overlapping over a run of ones.
        do_load(8'b0000_1111, 4'd4, 1'b1);
        for (int i = 0; i < 6; i++) begin
            do_bit(1'b1);
            check_output($sformatf("s3_match_b%0d", i + 1), 32'(match), (i >= 3) ? 1 : 0);
        end
        do_bit(1'b0);
        check_output("s3_match_zero", 32'(match), 0);
        do_bit(1'b1);
        check_output("s3_match_after_zero", 32'(match), 0);
        check_output("s3_count", 32'(match_count), 3);
        check_output("s3_fill_sat", 32'(fill), 8);

        // Scenario 4: len 1 matches every 1; the 2-bit counter saturates at 3.
        do_load(8'b0000_0001, 4'd1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            do_bit(1'b1);
            check_output($sformatf("s4_match_b%0d", i + 1), 32'(match_s), 1);
        end
        check_output("s4_small_sat", 32'(count_s), 3);
        check_output("s4_wide_count", 32'(match_count), 5);
        do_idle();
        check_output("s4_idle_match", 32'(match_s), 0);
        check_output("s4_small_hold", 32'(count_s), 3);
        do_load(8'b0000_0001, 4'd1, 1'b1);
        check_output("s4_small_clr", 32'(count_s), 0);

        // Scenario 5: rejected loads keep configuration, history and fill.
        do_load(8'b0000_1101, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) do_bit(s1_bits[i]);
        do_load(8'b1111_1111, 4'd0, 1'b0);
        check_output("s5_err_len0", 32'(cfg_err), 1);
        check_output("s5_fill_kept0", 32'(fill), 3);
        do_idle();
        check_output("s5_err_clears", 32'(cfg_err), 0);
        apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 4'd9, 1'b0);
        check_output("s5_err_len9", 32'(cfg_err), 1);
        check_output("s5_fill_kept9", 32'(fill), 3);
        for (int i = 3; i < 7; i++) begin
            do_bit(s1_bits[i]);
            check_output($sformatf("s5_match_b%0d", i + 1), 32'(match), 32'(s1_ovl[i]));
        end
        check_output("s5_count", 32'(match_count), 2);
        check_output("s5_fill", 32'(fill), 7);

        // Scenario 6: reset mid-stream discards progress and restores the reset configuration.
        do_load(8'b0000_1101, 4'd4, 1'b1);
        for (int i = 0; i < 3; i++) do_bit(s1_bits[i]);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, '0, 1'b0);
        check_output("s6_rst_fill", 32'(fill), 0);
        do_bit(1'b1);
        check_output("s6_no_match", 32'(match), 0);
        check_output("s6_fill", 32'(fill), 1);

        // en gaps between bits leave detection unchanged.
        do_load(8'b0000_1101, 4'd4, 1'b1);
        for (int i = 0; i < 7; i++) begin
            do_bit(s1_bits[i]);
            check_output($sformatf("s6_gap_match_b%0d", i + 1), 32'(match), 32'(s1_ovl[i]));
            do_idle();
            check_output($sformatf("s6_gap_idle_b%0d", i + 1), 32'(match), 0);
        end
        check_output("s6_gap_count", 32'(match_count), 2);

        // A load coinciding with en drops that bit, so 1,0,1 afterwards cannot complete 1101.
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b1, 8'b0000_1101, 4'd4, 1'b1);
        check_output("s6_load_en_fill", 32'(fill), 0);
        do_bit(1'b1);
        do_bit(1'b0);
        do_bit(1'b1);
        check_output("s6_load_en_match", 32'(match), 0);
        check_output("s6_load_en_fill3", 32'(fill), 3);

        $display("%0d/%0d checks passed", pass_count, total_count);
        $finish;
    end

endmodule
